// File: rtl/omniutil_pkg.sv
// Shared opcodes, framing bytes and FSM states for the OmniUtil command front-end.
package omniutil_pkg;

  localparam logic [7:0] OPC_CREDIT   = 8'h01;
  localparam logic [7:0] OPC_DEBIT    = 8'h02;
  localparam logic [7:0] OPC_READ     = 8'hFF;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_OPC,
    ST_AMT2,
    ST_AMT1,
    ST_AMT0,
    ST_CSUM,
    ST_ISSUE,
    ST_WAIT,
    ST_TX
  } state_t;

  function automatic logic opc_known(input logic [7:0] opc);
    return (opc == OPC_CREDIT) || (opc == OPC_DEBIT) || (opc == OPC_READ);
  endfunction

endpackage

// File: rtl/omniutil_tx_serializer.sv
// Byte serializer: loads up to five bytes (MSB byte first) and emits them
// on a valid/ready link, holding each byte for as long as the sink stalls.
module omniutil_tx_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [39:0] load_bytes,
  input  logic [2:0]  load_count,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [31:0] pend_q;
  logic [2:0]  left_q;

  // done marks the cycle whose edge hands off the final byte
  assign done = tx_valid && tx_ready && (left_q == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      left_q   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_bytes[39:32];
      pend_q   <= load_bytes[31:0];
      left_q   <= load_count - 3'd1;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (left_q == 3'd0) begin
        tx_valid <= 1'b0;
        tx_data  <= '0;
      end else begin
        tx_data <= pend_q[31:24];
        pend_q  <= {pend_q[23:0], 8'h00};
        left_q  <= left_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/omniutil_cmd_frontend.sv
// Framed byte-stream command deframer for the merit-balance engine.
// Define OMNIUTIL_FRONTEND_ACK_EN to answer every frame with ACK/NAK on tx.
module omniutil_cmd_frontend
  import omniutil_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         RESP_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] cmd,
  input  logic [31:0] response,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] err_count,
  output logic        busy
);

`ifdef OMNIUTIL_FRONTEND_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W = $clog2(RESP_LAT + 1);

  state_t              state_q, state_d;
  logic [7:0]          opc_q, a2_q, a1_q, a0_q;
  logic [7:0]          opc_d, a2_d, a1_d, a0_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         cmd_d;
  logic                err_inc, reject;
  logic                ser_load, ser_done;
  logic [39:0]         ser_bytes;
  logic [2:0]          ser_count;
  logic                rx_xfer, frame_good;

  assign rx_xfer    = rx_valid && rx_ready;
  assign frame_good = (rx_data == (opc_q ^ a2_q ^ a1_q ^ a0_q)) && opc_known(opc_q);

  // A bad frame and an inter-byte timeout are both funnelled through 'reject'
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    a2_d      = a2_q;
    a1_d      = a1_q;
    a0_d      = a0_q;
    idle_d    = idle_q;
    wait_d    = wait_q;
    cmd_d     = '0;
    err_inc   = 1'b0;
    reject    = 1'b0;
    ser_load  = 1'b0;
    ser_bytes = '0;
    ser_count = '0;
    case (state_q)
      ST_HUNT: begin
        if (rx_xfer && (rx_data == SYNC_BYTE)) begin
          state_d = ST_OPC;
          idle_d  = '0;
        end
      end
      ST_OPC, ST_AMT2, ST_AMT1, ST_AMT0, ST_CSUM: begin
        if (rx_xfer) begin
          idle_d = '0;
          case (state_q)
            ST_OPC:  begin opc_d = rx_data; state_d = ST_AMT2; end
            ST_AMT2: begin a2_d  = rx_data; state_d = ST_AMT1; end
            ST_AMT1: begin a1_d  = rx_data; state_d = ST_AMT0; end
            ST_AMT0: begin a0_d  = rx_data; state_d = ST_CSUM; end
            default: begin
              if (frame_good) begin
                state_d = ST_ISSUE;
                cmd_d   = {opc_q, a2_q, a1_q, a0_q};
              end else begin
                reject = 1'b1;
              end
            end
          endcase
        end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          reject = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_ISSUE: begin
        if (opc_q == OPC_READ) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end else if (ACK_EN) begin
          state_d   = ST_TX;
          ser_load  = 1'b1;
          ser_bytes = {ACK_BYTE, 32'h0};
          ser_count = 3'd1;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(RESP_LAT - 1)) begin
          state_d   = ST_TX;
          ser_load  = 1'b1;
          ser_bytes = ACK_EN ? {ACK_BYTE, response} : {response, 8'h00};
          ser_count = ACK_EN ? 3'd5 : 3'd4;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_TX: begin
        if (ser_done) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase

    if (reject) begin
      err_inc = 1'b1;
      if (ACK_EN) begin
        state_d   = ST_TX;
        ser_load  = 1'b1;
        ser_bytes = {NAK_BYTE, 32'h0};
        ser_count = 3'd1;
      end else begin
        state_d = ST_HUNT;
      end
    end
  end

  // rx_ready and busy are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      opc_q     <= '0;
      a2_q      <= '0;
      a1_q      <= '0;
      a0_q      <= '0;
      idle_q    <= '0;
      wait_q    <= '0;
      cmd       <= '0;
      rx_ready  <= 1'b1;
      busy      <= 1'b0;
      err_count <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      a2_q     <= a2_d;
      a1_q     <= a1_d;
      a0_q     <= a0_d;
      idle_q   <= idle_d;
      wait_q   <= wait_d;
      cmd      <= cmd_d;
      rx_ready <= !(state_d inside {ST_ISSUE, ST_WAIT, ST_TX});
      busy     <= (state_d != ST_HUNT);
      if (err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

  omniutil_tx_serializer u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_bytes (ser_bytes),
    .load_count (ser_count),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_omniutil_cmd_frontend.sv
// Self-checking bench for omniutil_cmd_frontend: directed frame table, hand-written
// timeout/reset sequences and randomized frames against a frame-level reference model.
module tb_omniutil_cmd_frontend;
  import omniutil_pkg::*;

  localparam int TIMEOUT = 1024;
`ifdef OMNIUTIL_FRONTEND_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] cmd;
  logic [31:0] response;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] err_count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int bp_mode = 0;
  int hold_cnt = 0;

  logic [31:0] eng_balance = 32'h0;
  logic [31:0] model_bal = 32'h0;
  logic [15:0] exp_err = 16'h0;
  logic [31:0] cmd_log[$];
  logic [7:0]  tx_log[$];
  logic [31:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  typedef struct {
    logic [63:0] frame;
    int          nbytes;
    int          bp;
    logic [31:0] cmd;
    logic [15:0] err;
    logic [39:0] tx;
    int          ntx;
  } vec_t;

  vec_t vecs[7];

  omniutil_cmd_frontend dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd       (cmd),
    .response  (response),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the merit-balance engine
  assign response = eng_balance;
  always @(posedge clk) begin
    if (cmd[31:24] == OPC_CREDIT) eng_balance <= eng_balance + {8'h00, cmd[23:0]};
    else if (cmd[31:24] == OPC_DEBIT) eng_balance <= eng_balance - {8'h00, cmd[23:0]};
  end

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Downstream sink: always ready, random stalls, or five stall cycles per byte
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1: tx_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (tx_valid) begin
          if (hold_cnt == 5) begin
            tx_ready = 1'b1;
            hold_cnt = 0;
          end else begin
            tx_ready = 1'b0;
            hold_cnt++;
          end
        end else begin
          tx_ready = 1'b0;
        end
      end
      default: tx_ready = 1'b1;
    endcase
  end

  // Observe cmd pulses and tx handoffs; a stalled byte must stay put
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("tx_hold", {31'h0, tx_valid, tx_data}, {31'h0, 1'b1, prev_data});
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (cmd != 32'h0) cmd_log.push_back(cmd);
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    if (n == 200) checkOutput("rx_ready_wait", 40'h0, 40'h1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 300) checkOutput({name, "_idle_wait"}, 40'h0, 40'h1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name);
    checkOutput({name, "_ncmd"}, 40'(cmd_log.size()), 40'(exp_cmd.size()));
    for (int i = 0; i < cmd_log.size() && i < exp_cmd.size(); i++)
      checkOutput($sformatf("%s_cmd%0d", name, i), {8'h0, cmd_log[i]}, {8'h0, exp_cmd[i]});
    checkOutput({name, "_ntx"}, 40'(tx_log.size()), 40'(exp_tx.size()));
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      checkOutput($sformatf("%s_tx%0d", name, i), {32'h0, tx_log[i]}, {32'h0, exp_tx[i]});
    checkOutput({name, "_err"}, {24'h0, err_count}, {24'h0, exp_err});
    checkOutput({name, "_idle"}, {36'h0, busy, rx_ready, tx_valid, |cmd}, {36'h0, 4'b0100});
    cmd_log.delete();
    tx_log.delete();
    exp_cmd.delete();
    exp_tx.delete();
  endtask

  // Frame-level reference: decide the frame's fate from its bytes alone
  task automatic model_frame(input logic [7:0] opc, input logic [23:0] amt, input logic [7:0] csum);
    bit good;
    good = (csum == (opc ^ amt[23:16] ^ amt[15:8] ^ amt[7:0])) &&
           (opc == 8'h01 || opc == 8'h02 || opc == 8'hFF);
    if (good) begin
      exp_cmd.push_back({opc, amt});
      if (ACK_EN) exp_tx.push_back(8'h06);
      if (opc == 8'h01) model_bal = model_bal + {8'h0, amt};
      else if (opc == 8'h02) model_bal = model_bal - {8'h0, amt};
      else for (int k = 3; k >= 0; k--) exp_tx.push_back(model_bal[8*k +: 8]);
    end else begin
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      if (ACK_EN) exp_tx.push_back(8'h15);
    end
  endtask

  task automatic send_model_frame(input logic [7:0] opc, input logic [23:0] amt,
                                  input logic [7:0] csum, input int max_gap);
    model_frame(opc, amt, csum);
    applyStimulus(8'hA5, $urandom_range(0, max_gap));
    applyStimulus(opc, $urandom_range(0, max_gap));
    applyStimulus(amt[23:16], $urandom_range(0, max_gap));
    applyStimulus(amt[15:8], $urandom_range(0, max_gap));
    applyStimulus(amt[7:0], $urandom_range(0, max_gap));
    applyStimulus(csum, $urandom_range(0, max_gap));
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  opc, csum, nb;
    logic [23:0] amt;

    vecs[0] = '{64'hA5_01_00_00_64_65_00_00, 6, 0, 32'h01000064, 16'd0,
                ACK_EN ? 40'h06_00000000 : 40'h0, ACK_EN ? 1 : 0};
    vecs[1] = '{64'hA5_FF_00_00_00_FF_00_00, 6, 2, 32'hFF000000, 16'd0,
                ACK_EN ? 40'h06_00000064 : 40'h00000064_00, ACK_EN ? 5 : 4};
    vecs[2] = '{64'hA5_01_00_00_64_00_00_00, 6, 0, 32'h0, 16'd1,
                ACK_EN ? 40'h15_00000000 : 40'h0, ACK_EN ? 1 : 0};
    vecs[3] = '{64'hA5_03_00_00_01_02_00_00, 6, 0, 32'h0, 16'd2,
                ACK_EN ? 40'h15_00000000 : 40'h0, ACK_EN ? 1 : 0};
    vecs[4] = '{64'h00_A4_A5_02_00_00_10_12, 8, 0, 32'h02000010, 16'd2,
                ACK_EN ? 40'h06_00000000 : 40'h0, ACK_EN ? 1 : 0};
    vecs[5] = '{64'hA5_FF_00_00_00_FF_00_00, 6, 1, 32'hFF000000, 16'd2,
                ACK_EN ? 40'h06_00000054 : 40'h00000054_00, ACK_EN ? 5 : 4};
    vecs[6] = '{64'hA5_01_00_A5_00_A4_00_00, 6, 0, 32'h0100A500, 16'd2,
                ACK_EN ? 40'h06_00000000 : 40'h0, ACK_EN ? 1 : 0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {cmd, tx_valid, rx_ready, busy, 5'h0},
                {32'h0, 1'b0, 1'b1, 1'b0, 5'h0});
    checkOutput("reset_tx_err", {16'h0, tx_data, err_count}, 40'h0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      bp_mode = vecs[v].bp;
      for (int i = 0; i < vecs[v].nbytes; i++)
        applyStimulus(vecs[v].frame[63 - 8*i -: 8], $urandom_range(0, 2));
      if (vecs[v].cmd != 32'h0) exp_cmd.push_back(vecs[v].cmd);
      for (int i = 0; i < vecs[v].ntx; i++) exp_tx.push_back(vecs[v].tx[39 - 8*i -: 8]);
      exp_err = vecs[v].err;
      wait_idle($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v));
    end
    model_bal = 32'h0000A554;

    bp_mode = 0;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    checkOutput("timeout_not_early", {39'h0, busy}, 40'h1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("timeout_hunt", {39'h0, busy}, 40'h0);
    exp_err = 16'd3;
    if (ACK_EN) exp_tx.push_back(8'h15);
    wait_idle("timeout");
    check_frame("timeout");
    send_model_frame(8'h02, 24'h000054, 8'h56, 2);
    wait_idle("after_timeout");
    check_frame("after_timeout");

    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs", {cmd, tx_valid, rx_ready, busy, 5'h0},
                {32'h0, 1'b0, 1'b1, 1'b0, 5'h0});
    checkOutput("midreset_err", {24'h0, err_count}, 40'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 16'h0;
    cmd_log.delete();
    tx_log.delete();
    send_model_frame(8'h01, 24'h000010, 8'h11, 1);
    wait_idle("after_reset");
    check_frame("after_reset");

    for (int f = 0; f < 30; f++) begin
      bp_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h00;
        applyStimulus(nb, $urandom_range(0, 2));
      end
      case ($urandom_range(0, 4))
        0: opc = 8'h01;
        1: opc = 8'h02;
        2: opc = 8'hFF;
        3: opc = 8'($urandom);
        default: opc = 8'h01;
      endcase
      amt  = 24'($urandom);
      csum = opc ^ amt[23:16] ^ amt[15:8] ^ amt[7:0];
      if ($urandom_range(0, 4) == 0) csum = csum ^ 8'($urandom_range(1, 255));
      send_model_frame(opc, amt, csum, 3);
      wait_idle($sformatf("rand%0d", f));
      check_frame($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
